// File: rtl/fpu_arbiter_if.sv
// Requester, response and fpu-side handshake bundle for fpu_arbiter.
// slave is the arbiter's view; master is the requesters plus fpu side.
interface fpu_arbiter_if #(parameter int N_REQ = 4);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][3:0]  req_operation;
    logic [N_REQ-1:0][31:0] req_data_a;
    logic [N_REQ-1:0][31:0] req_data_b;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [31:0]            rsp_result;
    logic                   rsp_error;
    logic                   busy;
    logic [IDW-1:0]         grant_id;
    logic [3:0]             fpu_operation;
    logic [31:0]            fpu_data_a;
    logic [31:0]            fpu_data_b;
    logic                   fpu_input_rdy;
    logic                   fpu_input_ack;
    logic                   fpu_output_rdy;
    logic                   fpu_output_ack;
    logic [31:0]            fpu_result;
    logic                   fpu_flush;

    modport slave (
        input  req_valid, req_operation, req_data_a, req_data_b, rsp_ready,
               fpu_input_ack, fpu_output_rdy, fpu_result,
        output req_ready, rsp_valid, rsp_result, rsp_error, busy, grant_id,
               fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy,
               fpu_output_ack, fpu_flush
    );

    modport master (
        output req_valid, req_operation, req_data_a, req_data_b, rsp_ready,
               fpu_input_ack, fpu_output_rdy, fpu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error, busy, grant_id,
               fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy,
               fpu_output_ack, fpu_flush
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of a single fpu among N_REQ requesters, one operation in
// flight, with a watchdog that aborts and flushes a hung fpu.
module fpu_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    fpu_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last, pick, idx, gid_q;
    logic             pick_vld, take, done, tmo;
    logic [7:0]       timer;
    logic [3:0]       op_q;
    logic [31:0]      a_q, b_q, res_q;
    logic             err_q, ird_q, oack_q, flush_q;
    logic [N_REQ-1:0] rdy, vld;

    // First valid requester after the last one served.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: if (pick_vld) begin
                take      = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: if (timer == TMO) begin
                tmo       = 1'b1;
                state_nxt = RESPOND;
            end else if (bus.fpu_input_ack) begin
                state_nxt = WAIT;
            end
            // A result on the timeout edge still counts as completion.
            WAIT: if (bus.fpu_output_rdy) begin
                done      = 1'b1;
                state_nxt = RESPOND;
            end else if (timer == TMO) begin
                tmo       = 1'b1;
                state_nxt = RESPOND;
            end
            RESPOND: if (bus.rsp_ready[gid_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = '0;
        vld = '0;
        if (!reset && state == IDLE && pick_vld) rdy[pick] = 1'b1;
        if (state == RESPOND) vld[gid_q] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= IDW'(N_REQ - 1);
            gid_q   <= '0;
            timer   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ird_q   <= 1'b0;
            oack_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ird_q   <= (state_nxt == ISSUE);
            oack_q  <= done;
            flush_q <= tmo;
            if (take) begin
                op_q  <= bus.req_operation[pick];
                a_q   <= bus.req_data_a[pick];
                b_q   <= bus.req_data_b[pick];
                gid_q <= pick;
                timer <= '0;
            end else if ((state == ISSUE || state == WAIT) && timer != 8'hFF) begin
                timer <= timer + 8'd1;
            end
            if (done) begin
                res_q <= bus.fpu_result;
                err_q <= 1'b0;
            end else if (tmo) begin
                res_q <= 32'hFFFF_FFFF;
                err_q <= 1'b1;
            end
            if (state == RESPOND && bus.rsp_ready[gid_q]) last <= gid_q;
        end
    end

    assign bus.req_ready      = rdy;
    assign bus.rsp_valid      = vld;
    assign bus.rsp_result     = res_q;
    assign bus.rsp_error      = err_q;
    assign bus.busy           = (state != IDLE);
    assign bus.grant_id       = gid_q;
    assign bus.fpu_operation  = op_q;
    assign bus.fpu_data_a     = a_q;
    assign bus.fpu_data_b     = b_q;
    assign bus.fpu_input_rdy  = ird_q;
    assign bus.fpu_output_ack = oack_q;
    assign bus.fpu_flush      = flush_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: behavioural fpu with configurable latency
// or hang, requesters driven per cycle, responses popped in predicted order.
module tb_fpu_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fpu_arbiter_if #(.N_REQ(N)) bus();
    fpu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   rep[N];
    int   cyc_n = 0, acc_cyc = 0, lat_meas = 0, ack_cnt = 0, flush_cnt = 0;
    bit   seen_rsp = 0;
    int   lat = 0;
    bit   hang = 0;

    bit          m_busy = 0;
    int          m_cnt = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;

    function automatic logic [31:0] fmodel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'h0 && a == 32'h3F80_0000 && b == 32'h3C23_D70A) return 32'h3F81_47AE;
        return (a + b) ^ {op, 28'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural fpu: ack one cycle, result after lat cycles, held until output_ack.
    always @(negedge clock) begin
        if (reset || bus.fpu_flush) begin
            m_busy             = 0;
            bus.fpu_input_ack  = 1'b0;
            bus.fpu_output_rdy = 1'b0;
            bus.fpu_result     = '0;
        end else begin
            bus.fpu_input_ack = 1'b0;
            if (bus.fpu_output_ack) begin
                bus.fpu_output_rdy = 1'b0;
                m_busy             = 0;
            end else if (m_busy) begin
                if (!bus.fpu_output_rdy) begin
                    if (m_cnt > 0) m_cnt--;
                    else if (!hang) begin
                        bus.fpu_output_rdy = 1'b1;
                        bus.fpu_result     = fmodel(m_op, m_a, m_b);
                    end
                end
            end else if (bus.fpu_input_rdy) begin
                m_busy            = 1;
                bus.fpu_input_ack = 1'b1;
                m_op              = bus.fpu_operation;
                m_a               = bus.fpu_data_a;
                m_b               = bus.fpu_data_b;
                m_cnt             = lat;
            end
        end
    end

    task automatic send(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int r);
        bus.req_operation[i] = op;
        bus.req_data_a[i]    = a;
        bus.req_data_b[i]    = b;
        bus.req_valid[i]     = 1'b1;
        rep[i]               = r;
    endtask

    task automatic expect_rsp(input int i, input logic [31:0] res, input logic err);
        exp_t e;
        e.id  = i;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    // One cycle: sample at negedge, update requesters just after posedge.
    task automatic tick();
        logic [N-1:0] acc;
        logic [N-1:0] oh;
        exp_t         e;
        @(negedge clock);
        cyc_n++;
        acc = bus.req_valid & bus.req_ready;
        if (acc != '0) acc_cyc = cyc_n;
        if (bus.fpu_output_ack) ack_cnt++;
        if (bus.fpu_flush) flush_cnt++;
        if (bus.rsp_valid != '0 && !seen_rsp) begin
            lat_meas = cyc_n - acc_cyc;
            seen_rsp = 1;
        end
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
            seen_rsp = 0;
            if (sb.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
            else begin
                e = sb.pop_front();
                for (int j = 0; j < N; j++) oh[j] = (j == e.id);
                chk("rsp_valid", bus.rsp_valid, oh);
                chk("rsp_grant", bus.grant_id, e.id);
                chk("rsp_result", bus.rsp_result, e.res);
                chk("rsp_error", bus.rsp_error, e.err);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (rep[i] > 0) begin
                    rep[i]--;
                    bus.req_data_a[i] = bus.req_data_a[i] + 32'd1;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0 && !bus.busy && bus.req_valid == '0) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(tag, ok, 1);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        #1;
        tick();
        tick();
        reset     = 1'b0;
        seen_rsp  = 0;
        ack_cnt   = 0;
        flush_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, e2res;
        bit          found;
        bus.req_valid     = '0;
        bus.req_operation = '0;
        bus.req_data_a    = '0;
        bus.req_data_b    = '0;
        bus.rsp_ready     = '1;
        for (int i = 0; i < N; i++) rep[i] = 0;

        // reset state, with a request pending to show req_ready is held off
        repeat (2) @(posedge clock);
        #1;
        bus.req_valid[1] = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_fpu_ctl", {bus.fpu_input_rdy, bus.fpu_output_ack, bus.fpu_flush}, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_rsp", {bus.rsp_error, bus.rsp_result}, 0);
        chk("rst_fpu_op_a", {bus.fpu_operation, bus.fpu_data_a}, 0);
        chk("rst_fpu_b", bus.fpu_data_b, 0);
        bus.req_valid = '0;
        do_reset();

        // single add on requester 0, zero-latency fpu
        lat = 0;
        expect_rsp(0, 32'h3F81_47AE, 1'b0);
        send(0, 4'h0, 32'h3F80_0000, 32'h3C23_D70A, 0);
        wait_done("t1_drain", 40);
        chk("t1_ack_pulses", ack_cnt, 1);
        chk("t1_latency", lat_meas, 3);   // accept edge + 2 edges, seen on negedges

        // all four valid from reset: served 0,1,2,3
        do_reset();
        lat = 2;
        for (int i = 0; i < N; i++) begin
            a = 32'h1000_0000 * (i + 1);
            b = 32'(i * 3 + 1);
            expect_rsp(i, fmodel(4'(i), a, b), 1'b0);
            send(i, 4'(i), a, b, 0);
        end
        wait_done("t2_drain", 120);
        chk("t2_ack_pulses", ack_cnt, N);

        // req1 held for three services, req2 once: order 1,2,1,1
        do_reset();
        lat = 1;
        expect_rsp(1, fmodel(4'h2, 32'h4000_0000, 32'd5), 1'b0);
        expect_rsp(2, fmodel(4'h3, 32'h4100_0000, 32'd7), 1'b0);
        expect_rsp(1, fmodel(4'h2, 32'h4000_0001, 32'd5), 1'b0);
        expect_rsp(1, fmodel(4'h2, 32'h4000_0002, 32'd5), 1'b0);
        send(1, 4'h2, 32'h4000_0000, 32'd5, 2);
        send(2, 4'h3, 32'h4100_0000, 32'd7, 0);
        wait_done("t3_drain", 120);

        // hung fpu: watchdog response and single flush pulse
        do_reset();
        hang = 1;
        expect_rsp(0, 32'hFFFF_FFFF, 1'b1);
        send(0, 4'h1, 32'h1234_5678, 32'h0000_0001, 0);
        wait_done("t4_drain", 60);
        chk("t4_flush_pulses", flush_cnt, 1);
        chk("t4_latency", lat_meas, T + 1);
        chk("t4_no_ack", ack_cnt, 0);
        hang = 0;

        // response held back: outputs stable, no new grant, fpu idle
        do_reset();
        lat = 0;
        bus.rsp_ready = '0;
        e2res = fmodel(4'h5, 32'h2222_0000, 32'h0000_0022);
        expect_rsp(2, e2res, 1'b0);
        expect_rsp(3, fmodel(4'h6, 32'h3333_0000, 32'h0000_0033), 1'b0);
        send(2, 4'h5, 32'h2222_0000, 32'h0000_0022, 0);
        send(3, 4'h6, 32'h3333_0000, 32'h0000_0033, 0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid != '0) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t5_rsp_seen", found, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_hold_valid", bus.rsp_valid, 4'b0100);
            chk("t5_hold_result", bus.rsp_result, e2res);
            chk("t5_hold_req_ready", bus.req_ready, 0);
            chk("t5_hold_fpu_idle", {bus.fpu_input_rdy, bus.fpu_output_ack}, 0);
        end
        bus.rsp_ready = '1;
        wait_done("t5_drain", 60);

        // reset while waiting on the fpu, then normal service
        do_reset();
        lat = 20;
        send(0, 4'h4, 32'h0BAD_F00D, 32'h1, 0);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.busy && !bus.fpu_input_rdy) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t6_in_wait", found, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rst_input_rdy", bus.fpu_input_rdy, 0);
        sb.delete();
        seen_rsp = 0;
        tick();
        tick();
        reset = 1'b0;
        lat   = 0;
        expect_rsp(0, fmodel(4'h7, 32'h0000_1000, 32'h0000_0200), 1'b0);
        send(0, 4'h7, 32'h0000_1000, 32'h0000_0200, 0);
        wait_done("t6_drain", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
